mpc_demux_14_32_reg: RTL

MPC_DEMUX_14_32_REG -- requirements
Module: mpc_demux_14_32_reg

---
 rtl/mpc_demux_14_32_reg.sv | 97 +++++++++
 1 files changed

// File: rtl/mpc_demux_14_32_reg.sv
// Registered 1-to-4 demultiplexer with a valid/ready handshake on every side.
// Each channel is a single-entry register, so one channel can move one word per cycle.
module mpc_demux_14_32_reg #(
  parameter int ID         = 0,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data0,
  output logic [DATA_WIDTH-1:0] out_data1,
  output logic [DATA_WIDTH-1:0] out_data2,
  output logic [DATA_WIDTH-1:0] out_data3,
  output logic                  out_valid0,
  output logic                  out_valid1,
  output logic                  out_valid2,
  output logic                  out_valid3,
  input  logic                  out_ready0,
  input  logic                  out_ready1,
  input  logic                  out_ready2,
  input  logic                  out_ready3,
  output logic [15:0]           xfer_cnt
);

  localparam int NCH = 4;

  // ID is a pure instance tag; it is only range-checked here.
  if (ID < 0) begin : g_negative_id
  end

  logic [NCH-1:0]        full_q, full_d;
  logic [NCH-1:0]        out_ready_v;
  logic [NCH-1:0]        drain;
  logic [NCH-1:0]        wr_en;
  logic [DATA_WIDTH-1:0] data_q [NCH];
  logic [DATA_WIDTH-1:0] data_d [NCH];
  logic [15:0]           cnt_q, cnt_d;
  logic                  accept;

  assign out_ready_v = {out_ready3, out_ready2, out_ready1, out_ready0};

  // A full channel whose sink is taking its word this cycle can accept a new one.
  assign drain    = full_q & out_ready_v;
  assign in_ready = ap_rst_n & (~full_q[in_sel] | out_ready_v[in_sel]);
  assign accept   = in_valid & in_ready;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    wr_en = '0;
    if (accept) begin
      wr_en[in_sel] = 1'b1;
    end
  end

  // A write wins over a drain, which keeps a simultaneously drained channel full.
  assign full_d = (full_q & ~drain) | wr_en;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      data_d[k] = wr_en[k] ? in_data : data_q[k];
    end
  end

  assign cnt_d = cnt_q + 16'(accept);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      full_q <= '0;
      cnt_q  <= '0;
      // NOTE: data registers are reset too, since out_data must read 0 while in reset.
      for (int k = 0; k < NCH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      full_q <= full_d;
      cnt_q  <= cnt_d;
      for (int k = 0; k < NCH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_data0  = data_q[0];
  assign out_data1  = data_q[1];
  assign out_data2  = data_q[2];
  assign out_data3  = data_q[3];
  assign out_valid0 = full_q[0];
  assign out_valid1 = full_q[1];
  assign out_valid2 = full_q[2];
  assign out_valid3 = full_q[3];
  assign xfer_cnt   = cnt_q;

endmodule
